jbr_sequencer: RTL

Multi-cycle sequencer that owns the program counter register and drives the jump/branch decision for the custom control-flow instructions (bmv, bz, jsp, balrn, jmadd). It sits between the decode stage, which supplies the 3-bit instruction select, flags and operands, and the data memory port. It issues the data-memory reads that memory-indirect targets need, stalls decode while a read is outstanding, and commits the next PC.

---
 rtl/jbr_sequencer_pkg.sv | 25 ++
 rtl/jbr_sequencer_if.sv | 33 +++
 rtl/jbr_target_sel.sv | 46 ++++
 rtl/jbr_sequencer.sv | 139 +++++++++++++
 4 files changed

// File: rtl/jbr_sequencer_pkg.sv
// Shared types for the jump/branch sequencer: word width, nis encodings, FSM states.
// No logic; imported by the interface, the target selector and the top.
// Encodings match the decode stage's {nis2,nis1,nis0} field.
package jbr_sequencer_pkg;

  localparam int WORD_W = 32;

  typedef logic [WORD_W-1:0] word_t;

  // Instruction select; 3'b011 and 3'b111 are unassigned and reported as illegal.
  typedef enum logic [2:0] {
    NIS_NONE  = 3'b000,
    NIS_BMV   = 3'b001,
    NIS_BZ    = 3'b010,
    NIS_JSP   = 3'b100,
    NIS_BALRN = 3'b101,
    NIS_JMADD = 3'b110
  } nis_e;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MEM  = 1'b1
  } state_e;

endpackage

// File: rtl/jbr_sequencer_if.sv
// Decode-side and data-memory-side signals of the sequencer, bundled.
// master = decode + memory environment, slave = the sequencer itself.
// op_valid/op_ready handshake on decode; mem_req/mem_ready on memory.
interface jbr_sequencer_if;

  logic                         op_valid;
  logic                         op_ready;
  logic [2:0]                   nis;
  logic                         flag_n;
  logic                         flag_z;
  logic                         flag_v;
  jbr_sequencer_pkg::word_t     pc4;
  jbr_sequencer_pkg::word_t     reg1;
  logic [25:0]                  jmp_addr;
  jbr_sequencer_pkg::word_t     mem_ea;
  logic                         mem_req;
  jbr_sequencer_pkg::word_t     mem_addr;
  logic                         mem_ready;
  jbr_sequencer_pkg::word_t     mem_rdata;

  modport master (
    output op_valid, nis, flag_n, flag_z, flag_v, pc4, reg1, jmp_addr, mem_ea,
    output mem_ready, mem_rdata,
    input  op_ready, mem_req, mem_addr
  );

  modport slave (
    input  op_valid, nis, flag_n, flag_z, flag_v, pc4, reg1, jmp_addr, mem_ea,
    input  mem_ready, mem_rdata,
    output op_ready, mem_req, mem_addr
  );

endinterface

// File: rtl/jbr_target_sel.sv
// Next-PC / taken selection for ops that resolve without a memory read.
// Purely combinational, zero latency.
// No backpressure; go_mem tells the FSM the op needs a target fetch instead.
module jbr_target_sel
  import jbr_sequencer_pkg::*;
(
  input  logic [2:0]  nis,
  input  logic        flag_n,
  input  logic        flag_z,
  input  logic        flag_v,
  input  word_t       pc4,
  input  word_t       reg1,
  input  logic [25:0] jmp_addr,
  output word_t       target,
  output logic        taken,
  output logic        go_mem,
  output logic        illegal
);

  // Fall through to pc4 unless a branch condition holds or a fetch is needed.
  always_comb begin
    target  = pc4;
    taken   = 1'b0;
    go_mem  = 1'b0;
    illegal = 1'b0;
    case (nis)
      NIS_BZ: begin
        if (flag_z) begin
          target = {6'b0, jmp_addr};
          taken  = 1'b1;
        end
      end
      NIS_BALRN: begin
        if (flag_n) begin
          target = reg1;
          taken  = 1'b1;
        end
      end
      NIS_BMV:              go_mem  = flag_v;
      NIS_JSP, NIS_JMADD:   go_mem  = 1'b1;
      3'b011, 3'b111:       illegal = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: rtl/jbr_sequencer.sv
// PC owner for bmv/bz/jsp/balrn/jmadd; fetches memory-indirect targets (JBR_TIMEOUT_EN adds a wait limit).
// Non-memory ops: pc on the accepting edge. Memory ops: pc on the first mem_ready edge (>= 2 edges).
// op_ready low while a read is outstanding; decode holds; mem_addr held while mem_req high.
module jbr_sequencer
  import jbr_sequencer_pkg::*;
#(
  parameter word_t       RESET_PC       = 32'h0000_0000,
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  jbr_sequencer_if.slave  bus,
  output word_t           pc,
  output logic            taken,
  output logic            illegal,
  output logic            fault
);

  state_e state_q, state_d;
  word_t  pc_q, pc_d;
  word_t  mem_addr_q, mem_addr_d;
  logic   taken_q, taken_d;
  logic   illegal_q, illegal_d;

  word_t  sel_target;
  logic   sel_taken, sel_go_mem, sel_illegal;

`ifdef JBR_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             fault_q, fault_d;
  word_t            pc4_q, pc4_d;
`endif

  jbr_target_sel u_target_sel (
    .nis      (bus.nis),
    .flag_n   (bus.flag_n),
    .flag_z   (bus.flag_z),
    .flag_v   (bus.flag_v),
    .pc4      (bus.pc4),
    .reg1     (bus.reg1),
    .jmp_addr (bus.jmp_addr),
    .target   (sel_target),
    .taken    (sel_taken),
    .go_mem   (sel_go_mem),
    .illegal  (sel_illegal)
  );

  // Next-state and next-PC decisions; pulses default low every cycle.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    mem_addr_d = mem_addr_q;
    taken_d    = 1'b0;
    illegal_d  = 1'b0;
`ifdef JBR_TIMEOUT_EN
    cnt_d      = cnt_q;
    fault_d    = fault_q;
    pc4_d      = pc4_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (bus.op_valid) begin
          if (sel_go_mem) begin
            state_d    = ST_MEM;
            mem_addr_d = bus.mem_ea;
`ifdef JBR_TIMEOUT_EN
            cnt_d      = '0;
            pc4_d      = bus.pc4;
`endif
          end else begin
            pc_d      = sel_target;
            taken_d   = sel_taken;
            illegal_d = sel_illegal;
          end
        end
      end
      ST_MEM: begin
        // A read completing on the expiry cycle still commits normally.
        if (bus.mem_ready) begin
          pc_d    = bus.mem_rdata;
          taken_d = 1'b1;
          state_d = ST_IDLE;
        end
`ifdef JBR_TIMEOUT_EN
        else if (cnt_q == CNT_LAST) begin
          pc_d    = pc4_q;
          fault_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, PC and registered pulses; reset abandons any outstanding read.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      pc_q       <= RESET_PC;
      mem_addr_q <= '0;
      taken_q    <= 1'b0;
      illegal_q  <= 1'b0;
`ifdef JBR_TIMEOUT_EN
      cnt_q      <= '0;
      fault_q    <= 1'b0;
      pc4_q      <= '0;
`endif
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      mem_addr_q <= mem_addr_d;
      taken_q    <= taken_d;
      illegal_q  <= illegal_d;
`ifdef JBR_TIMEOUT_EN
      cnt_q      <= cnt_d;
      fault_q    <= fault_d;
      pc4_q      <= pc4_d;
`endif
    end
  end

  assign bus.op_ready = (state_q == ST_IDLE);
  assign bus.mem_req  = (state_q == ST_MEM);
  assign bus.mem_addr = mem_addr_q;
  assign pc           = pc_q;
  assign taken        = taken_q;
  assign illegal      = illegal_q;
`ifdef JBR_TIMEOUT_EN
  assign fault        = fault_q;
`else
  assign fault        = 1'b0;
`endif

endmodule
